// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM responder: transfer/response codes,
// data-phase state encoding and the address-phase classifier.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_OK,
    CLS_ERR
  } xfer_class_e;

  // BUSY is never legal here, so it is answered like an out-of-window access.
  function automatic xfer_class_e classify(input logic sel, input logic [1:0] trans,
                                           input logic in_win);
    xfer_class_e cls;
    cls = CLS_NONE;
    if (!sel || trans == HTRANS_IDLE) cls = CLS_NONE;
    else if (trans == HTRANS_BUSY) cls = CLS_ERR;
    else if ((trans == HTRANS_NONSEQ || trans == HTRANS_SEQ) && in_win) cls = CLS_OK;
    else cls = CLS_ERR;
    return cls;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus signals seen by one responder, with master and slave views.
interface ahb_interface #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 8
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// Byte-lane SRAM behind the responder: write on the clock edge, read combinationally.
module ahb_slave_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: window decode, data-phase FSM with wait-state
// down-counter, and a two-cycle ERROR response.
//
// state   | meaning
// IDLE    | no data phase pending, ready for an address phase
// WAIT    | OKAY data phase; low while the counter is nonzero, completes at zero
// ERR1    | first ERROR cycle (HREADYOUT low)
// ERR2    | second ERROR cycle (HREADYOUT high)
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 21,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 21'h10_0000,
  parameter int unsigned       MEM_DEPTH   = 1024,
  parameter int unsigned       WAIT_STATES = 1
) (
  input logic         HCLK,
  input logic         HRESET,
  ahb_interface.slave bus
);
  localparam int unsigned     IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] WIN_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [3:0]      WS      = 4'(WAIT_STATES);

  ahb_slv_state_e    state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              in_win, ready, done_ok, mem_we;
  xfer_class_e       cls;
  logic [DATA_W-1:0] mem_rdata;

  assign in_win  = (bus.HADDR >= BASE_ADDR) && ({1'b0, bus.HADDR} < WIN_END);
  assign cls     = classify(bus.HSEL, bus.HTRANS, in_win);
  assign ready   = !((state_q == ST_WAIT && cnt_q != 4'd0) || state_q == ST_ERR1);
  assign done_ok = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we  = done_ok && write_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      ST_ERR1: state_d = ST_ERR2;
      default: ;
    endcase
    // Any cycle with HREADYOUT high ends the current data phase and may take a new one.
    if (ready) begin
      state_d = ST_IDLE;
      if (bus.HREADY) begin
        case (cls)
          CLS_OK: begin
            state_d = ST_WAIT;
            cnt_d   = WS;
            idx_d   = bus.HADDR[IDX_W-1:0] - BASE_ADDR[IDX_W-1:0];
            write_d = bus.HWRITE;
          end
          CLS_ERR: state_d = ST_ERR1;
          default: ;
        endcase
      end
    end
  end

  ahb_slave_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = (done_ok && !write_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised and directed bench for ahb_sram_slave with one and zero wait states,
// checked every cycle against a transaction-timeline model of the bus responses.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam logic [20:0] BASE  = 21'h10_0000;
  localparam int          DEPTH = 1024;

  typedef struct packed {
    logic       rdy;
    logic       resp;
    logic       rd;
    logic       wr;
    logic [9:0] idx;
  } ent_t;

  localparam ent_t IDLE_ENT = '{rdy: 1'b1, resp: 1'b0, rd: 1'b0, wr: 1'b0, idx: 10'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        which = 1'b0;
  logic        c_hsel = 1'b0;
  logic [20:0] c_addr = '0;
  logic [1:0]  c_trans = HTRANS_IDLE;
  logic        c_write = 1'b0;
  logic [7:0]  c_wdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_interface #(.ADDR_W(21), .DATA_W(8)) bus_a ();
  ahb_interface #(.ADDR_W(21), .DATA_W(8)) bus_b ();

  assign bus_a.HSEL   = c_hsel & ~which;
  assign bus_a.HADDR  = c_addr;
  assign bus_a.HTRANS = c_trans;
  assign bus_a.HWRITE = c_write;
  assign bus_a.HWDATA = c_wdata;
  assign bus_a.HREADY = bus_a.HREADYOUT;
  assign bus_b.HSEL   = c_hsel & which;
  assign bus_b.HADDR  = c_addr;
  assign bus_b.HTRANS = c_trans;
  assign bus_b.HWRITE = c_write;
  assign bus_b.HWDATA = c_wdata;
  assign bus_b.HREADY = bus_b.HREADYOUT;

  ahb_sram_slave #(.WAIT_STATES(1)) u_a (.HCLK(clk), .HRESET(rst), .bus(bus_a));
  ahb_sram_slave #(.WAIT_STATES(0)) u_b (.HCLK(clk), .HRESET(rst), .bus(bus_b));

  // Model: per responder, a queue of expected (ready, resp, read/write) cycles.
  ent_t       q_a[$];
  ent_t       q_b[$];
  ent_t       cur_q[$];
  ent_t       e;
  logic [7:0] mdl_mem [2][DEPTH];
  logic [7:0] last_rd [2];
  int         last_low [2];
  int         low_run [2];
  int         ws_of [2] = '{1, 0};
  logic       m_hsel, m_hwrite, m_rdy, m_resp, m_win;
  logic [20:0] m_haddr;
  logic [1:0]  m_htrans;
  logic [7:0]  m_hwdata, m_data, exp_d;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        cur_q = q_a;
        m_hsel = bus_a.HSEL; m_haddr = bus_a.HADDR; m_htrans = bus_a.HTRANS;
        m_hwrite = bus_a.HWRITE; m_hwdata = bus_a.HWDATA;
        m_rdy = bus_a.HREADYOUT; m_resp = bus_a.HRESP; m_data = bus_a.HRDATA;
      end else begin
        cur_q = q_b;
        m_hsel = bus_b.HSEL; m_haddr = bus_b.HADDR; m_htrans = bus_b.HTRANS;
        m_hwrite = bus_b.HWRITE; m_hwdata = bus_b.HWDATA;
        m_rdy = bus_b.HREADYOUT; m_resp = bus_b.HRESP; m_data = bus_b.HRDATA;
      end
      if (rst) cur_q.delete();
      e = (cur_q.size() > 0) ? cur_q[0] : IDLE_ENT;
      exp_d = (e.rd && e.rdy) ? mdl_mem[k][e.idx] : 8'h00;
      n_vec++;
      if (m_rdy !== e.rdy || m_resp !== e.resp || m_data !== exp_d) begin
        n_bad++;
        $display("FAIL cycle dut%0d t=%0t: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                 k, $time, m_rdy, m_resp, m_data, e.rdy, e.resp, exp_d);
      end
      if (!rst) begin
        if (e.rdy) begin
          if (e.rd) begin
            last_rd[k]  = m_data;
            last_low[k] = low_run[k];
          end
          if (e.wr) mdl_mem[k][e.idx] = m_hwdata;
          low_run[k] = 0;
          if (cur_q.size() > 0) void'(cur_q.pop_front());
          if (m_hsel && m_htrans != HTRANS_IDLE) begin
            m_win = (int'(m_haddr) >= int'(BASE)) && (int'(m_haddr) < int'(BASE) + DEPTH);
            if (m_htrans[1] && m_win) begin
              repeat (ws_of[k]) cur_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
              cur_q.push_back('{1'b1, 1'b0, !m_hwrite, m_hwrite, 10'(m_haddr - BASE)});
            end else begin
              cur_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 10'd0});
              cur_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 10'd0});
            end
          end
        end else begin
          low_run[k]++;
          void'(cur_q.pop_front());
        end
      end
      if (k == 0) q_a = cur_q;
      else        q_b = cur_q;
    end
  end

  task automatic chk(input string nm, input logic er, input logic es, input logic [7:0] ed);
    logic ar, as;
    logic [7:0] ad;
    ar = which ? bus_b.HREADYOUT : bus_a.HREADYOUT;
    as = which ? bus_b.HRESP : bus_a.HRESP;
    ad = which ? bus_b.HRDATA : bus_a.HRDATA;
    n_vec++;
    if (ar !== er || as !== es || ad !== ed) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
               nm, ar, as, ad, er, es, ed);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Drives one address phase and holds it until the selected responder is ready.
  task automatic issue(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [20:0] ad, input logic [7:0] wd);
    logic rdy;
    int   n;
    n = 0;
    c_hsel = sel; c_trans = tr; c_write = wr; c_addr = ad;
    do begin
      @(negedge clk);
      rdy = which ? bus_b.HREADY : bus_a.HREADY;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue-timeout: ready stayed %b, want 1", rdy);
    end
    c_wdata = wd;
    c_hsel = 1'b0; c_trans = HTRANS_IDLE; c_write = 1'b0;
  endtask

  task automatic flush();
    issue(1'b0, HTRANS_IDLE, 1'b0, BASE, c_wdata);
  endtask

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, BASE + 21'(i), 8'($urandom));
    flush();
  endtask

  task automatic random_run(input int n);
    logic [20:0] ad;
    logic [1:0]  tr;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      tr = (r < 2) ? HTRANS_IDLE : (r == 2) ? HTRANS_BUSY : (r < 7) ? HTRANS_NONSEQ : HTRANS_SEQ;
      r = $urandom_range(0, 19);
      if (r == 0)      ad = 21'($urandom);
      else if (r == 1) ad = BASE - 21'd1;
      else if (r == 2) ad = BASE + 21'(DEPTH);
      else if (r == 3) ad = BASE + 21'(DEPTH - 1);
      else             ad = BASE + 21'($urandom_range(0, DEPTH - 1));
      issue($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), ad, 8'($urandom));
    end
    flush();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset-idle", 1'b1, 1'b0, 8'h00);
    end
    @(posedge clk); #1;

    // One wait state.
    which = 1'b0;
    init_mem();
    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h10_0000, 8'h5A);
    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h10_0002, 8'h3C);
    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h10_0005, 8'hAA);
    issue(1'b1, HTRANS_NONSEQ, 1'b0, 21'h10_0005, 8'h00);
    flush();
    chk_val("ws1-read-data", int'(last_rd[0]), 8'hAA);
    chk_val("ws1-read-waits", last_low[0], 1);

    issue(1'b1, HTRANS_BUSY, 1'b1, 21'h10_0005, 8'hFF);
    @(negedge clk); chk("busy-err1", 1'b0, 1'b1, 8'h00);
    @(negedge clk); chk("busy-err2", 1'b1, 1'b1, 8'h00);
    issue(1'b1, HTRANS_NONSEQ, 1'b0, 21'h10_0005, 8'h00);
    flush();
    chk_val("busy-no-write", int'(last_rd[0]), 8'hAA);

    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h20_0000, 8'h55);
    @(negedge clk); chk("oow-err1", 1'b0, 1'b1, 8'h00);
    @(negedge clk); chk("oow-err2", 1'b1, 1'b1, 8'h00);
    issue(1'b1, HTRANS_NONSEQ, 1'b0, 21'h10_0000, 8'h00);
    flush();
    chk_val("oow-prior-value", int'(last_rd[0]), 8'h5A);

    // Zero wait states, pipelined write then read.
    which = 1'b1;
    init_mem();
    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h10_0001, 8'h11);
    chk("ws0-write-phase", 1'b1, 1'b0, 8'h00);
    issue(1'b1, HTRANS_NONSEQ, 1'b0, 21'h10_0001, 8'h00);
    @(negedge clk); chk("ws0-read", 1'b1, 1'b0, 8'h11);
    flush();
    chk_val("ws0-read-waits", last_low[1], 0);

    which = 1'b0;
    random_run(400);
    which = 1'b1;
    random_run(400);

    // Reset in the middle of a write's wait state.
    which = 1'b0;
    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h10_0002, 8'h3C);
    flush();
    issue(1'b1, HTRANS_NONSEQ, 1'b1, 21'h10_0002, 8'h77);
    chk("rst-pre-wait", 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b1;
    #1 chk("rst-immediate", 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    issue(1'b1, HTRANS_NONSEQ, 1'b0, 21'h10_0002, 8'h00);
    flush();
    chk_val("rst-dropped-write", int'(last_rd[0]), 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
